// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: arbitrates exceptions, ERET and interrupts, drives the
// hardware-write side of Status/Cause/EPC/BadVAddr/Count and issues a one-cycle redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] statusQ,
  input  logic [31:0] causeQ,
  input  logic [31:0] epcQ,
  input  logic [31:0] countQ,
  input  logic [31:0] compareQ,
  input  logic        excValid,
  input  logic [4:0]  excCode,
  input  logic [31:0] excPc,
  input  logic        excInDs,
  input  logic [31:0] excBadVa,
  input  logic        excBadVaValid,
  input  logic        eretValid,
  input  logic        instValid,
  input  logic [31:0] instPc,
  input  logic        instInDs,
  input  logic [4:0]  hwIrq,
  input  logic        compareWrite,
  output logic [31:0] statusHDin,
  output logic [31:0] statusHWe,
  output logic [31:0] causeHDin,
  output logic [31:0] causeHWe,
  output logic [31:0] epcHDin,
  output logic [31:0] epcHWe,
  output logic [31:0] badVaHDin,
  output logic [31:0] badVaHWe,
  output logic [31:0] countHDin,
  output logic [31:0] countHWe,
  output logic        redirect,
  output logic [31:0] redirectPc
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t            state, stateNxt;
  logic [DIV_W-1:0]  divCnt;
  logic              divWrap;
  logic              timerLatch, timerLatchNxt;
  logic              irqPending, takeExc, takeEret, takeIrq, entry;
  logic [31:0]       entryPc;
  logic              entryDs;
  logic [4:0]        entryCode;

  logic [31:0] statusHDinN, statusHWeN, causeHDinN, causeHWeN, epcHDinN, epcHWeN;
  logic [31:0] badVaHDinN, badVaHWeN, countHDinN, countHWeN, redirectPcN;
  logic        redirectN;

  // Event arbitration: exception beats ERET beats interrupt; nothing is taken while flushing.
  always_comb begin
    irqPending    = statusQ[0] & ~statusQ[1] & ~statusQ[2] & instValid
                  & (|(causeQ[15:8] & statusQ[15:8]));
    takeExc       = (state == IDLE) & excValid;
    takeEret      = (state == IDLE) & ~excValid & eretValid;
    takeIrq       = (state == IDLE) & ~excValid & ~eretValid & irqPending;
    entry         = takeExc | takeIrq;
    entryPc       = takeExc ? excPc : instPc;
    entryDs       = takeExc ? excInDs : instInDs;
    entryCode     = takeExc ? excCode : 5'd0;
    divWrap       = (divCnt == DIV_W'(COUNT_DIV - 1));
    timerLatchNxt = compareWrite ? 1'b0 : ((countQ == compareQ) ? 1'b1 : timerLatch);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (takeExc | takeEret | takeIrq) stateNxt = COMMIT;
      COMMIT:  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    statusHDinN = '0;
    statusHWeN  = '0;
    causeHWeN   = 32'h4000_FC00;
    causeHDinN  = '0;
    causeHDinN[30]    = timerLatchNxt;
    causeHDinN[15]    = timerLatchNxt;
    causeHDinN[14:10] = hwIrq;
    epcHDinN    = '0;
    epcHWeN     = '0;
    badVaHDinN  = '0;
    badVaHWeN   = '0;
    countHWeN   = divWrap ? '1 : '0;
    countHDinN  = divWrap ? countQ + 32'd1 : '0;
    redirectN   = 1'b0;
    redirectPcN = '0;
    if (entry) begin
      statusHWeN[1]    = 1'b1;
      statusHDinN[1]   = 1'b1;
      causeHWeN[6:2]   = 5'h1f;
      causeHDinN[6:2]  = entryCode;
      // A nested entry (EXL already set) keeps the original EPC and BD.
      if (!statusQ[1]) begin
        epcHWeN        = '1;
        epcHDinN       = entryDs ? entryPc - 32'd4 : entryPc;
        causeHWeN[31]  = 1'b1;
        causeHDinN[31] = entryDs;
      end
      if (takeExc && excBadVaValid) begin
        badVaHWeN  = '1;
        badVaHDinN = excBadVa;
      end
      redirectN   = 1'b1;
      redirectPcN = EXC_VECTOR;
    end else if (takeEret) begin
      statusHWeN[1] = 1'b1;
      redirectN     = 1'b1;
      redirectPcN   = epcQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt     <= '0;
      timerLatch <= 1'b0;
      statusHDin <= '0;
      statusHWe  <= '0;
      causeHDin  <= '0;
      causeHWe   <= '0;
      epcHDin    <= '0;
      epcHWe     <= '0;
      badVaHDin  <= '0;
      badVaHWe   <= '0;
      countHDin  <= '0;
      countHWe   <= '0;
      redirect   <= 1'b0;
      redirectPc <= '0;
    end else begin
      divCnt     <= divWrap ? '0 : divCnt + DIV_W'(1);
      timerLatch <= timerLatchNxt;
      statusHDin <= statusHDinN;
      statusHWe  <= statusHWeN;
      causeHDin  <= causeHDinN;
      causeHWe   <= causeHWeN;
      epcHDin    <= epcHDinN;
      epcHWe     <= epcHWeN;
      badVaHDin  <= badVaHDinN;
      badVaHWe   <= badVaHWeN;
      countHDin  <= countHDinN;
      countHWe   <= countHWeN;
      redirect   <= redirectN;
      redirectPc <= redirectPcN;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then random traffic, checked against a reference model.
module tb_cp0_exc_ctrl;

  localparam int          COUNT_DIV = 2;
  localparam logic [31:0] VEC       = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] statusQ, causeQ, epcQ, countQ, compareQ;
  logic        excValid, excInDs, excBadVaValid, eretValid, instValid, instInDs, compareWrite;
  logic [4:0]  excCode, hwIrq;
  logic [31:0] excPc, excBadVa, instPc;
  logic [31:0] statusHDin, statusHWe, causeHDin, causeHWe, epcHDin, epcHWe;
  logic [31:0] badVaHDin, badVaHWe, countHDin, countHWe, redirectPc;
  logic        redirect;

  int nCmp = 0;
  int nErr = 0;

  // Reference-model state
  bit mCommit;
  int mTicks;
  bit mLatch;

  // Register-file emulation: writes issued in one cycle land one cycle later.
  logic [31:0] pStWe, pSt, pCaWe, pCa, pEpWe, pEp, pCnWe, pCn;

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .rst(rst),
    .statusQ(statusQ), .causeQ(causeQ), .epcQ(epcQ), .countQ(countQ), .compareQ(compareQ),
    .excValid(excValid), .excCode(excCode), .excPc(excPc), .excInDs(excInDs),
    .excBadVa(excBadVa), .excBadVaValid(excBadVaValid), .eretValid(eretValid),
    .instValid(instValid), .instPc(instPc), .instInDs(instInDs), .hwIrq(hwIrq),
    .compareWrite(compareWrite),
    .statusHDin(statusHDin), .statusHWe(statusHWe), .causeHDin(causeHDin), .causeHWe(causeHWe),
    .epcHDin(epcHDin), .epcHWe(epcHWe), .badVaHDin(badVaHDin), .badVaHWe(badVaHWe),
    .countHDin(countHDin), .countHWe(countHWe), .redirect(redirect), .redirectPc(redirectPc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict from current inputs, clock, compare every output.
  task automatic step();
    logic [31:0] eSt, eStWe, eCa, eCaWe, eEp, eEpWe, eBv, eBvWe, eCn, eCnWe, eRpc, pc;
    logic        eRed, irq, ds;
    int          ev;
    eSt = '0; eStWe = '0; eCa = '0; eCaWe = '0; eEp = '0; eEpWe = '0;
    eBv = '0; eBvWe = '0; eCn = '0; eCnWe = '0; eRpc = '0; eRed = 1'b0;
    if (rst) begin
      mCommit = 0; mTicks = 0; mLatch = 0;
    end else begin
      irq = statusQ[0] && !statusQ[1] && !statusQ[2] && instValid
            && ((causeQ[15:8] & statusQ[15:8]) != 8'd0);
      ev  = mCommit ? 0 : excValid ? 1 : eretValid ? 2 : irq ? 3 : 0;
      if (compareWrite) mLatch = 0;
      else if (countQ == compareQ) mLatch = 1;
      mTicks++;
      if (mTicks % COUNT_DIV == 0) begin
        eCnWe = '1;
        eCn   = countQ + 1;
      end
      eCaWe = 32'h4000_FC00;
      eCa   = {1'b0, mLatch, 14'b0, mLatch, hwIrq, 10'b0};
      if (ev == 1 || ev == 3) begin
        pc = (ev == 1) ? excPc : instPc;
        ds = (ev == 1) ? excInDs : instInDs;
        eStWe = 32'h2; eSt = 32'h2;
        eCaWe = eCaWe | 32'h7C;
        eCa   = eCa | ({27'b0, ((ev == 1) ? excCode : 5'd0)} << 2);
        if (!statusQ[1]) begin
          eEpWe = '1;
          eEp   = ds ? pc - 4 : pc;
          eCaWe = eCaWe | 32'h8000_0000;
          eCa   = eCa | (ds ? 32'h8000_0000 : 32'h0);
        end
        if (ev == 1 && excBadVaValid) begin
          eBvWe = '1; eBv = excBadVa;
        end
        eRed = 1'b1; eRpc = VEC;
      end else if (ev == 2) begin
        eStWe = 32'h2; eRed = 1'b1; eRpc = epcQ;
      end
      mCommit = (ev != 0);
    end
    @(posedge clk);
    #1;
    statusQ = (statusQ & ~pStWe) | (pSt & pStWe);
    causeQ  = (causeQ & ~pCaWe) | (pCa & pCaWe);
    epcQ    = (epcQ & ~pEpWe) | (pEp & pEpWe);
    countQ  = (countQ & ~pCnWe) | (pCn & pCnWe);
    pStWe = statusHWe; pSt = statusHDin; pCaWe = causeHWe; pCa = causeHDin;
    pEpWe = epcHWe; pEp = epcHDin; pCnWe = countHWe; pCn = countHDin;
    chk("statusHWe", statusHWe, eStWe);
    chk("statusHDin", statusHDin, eSt);
    chk("causeHWe", causeHWe, eCaWe);
    chk("causeHDin", causeHDin, eCa);
    chk("epcHWe", epcHWe, eEpWe);
    if (eEpWe != 0) chk("epcHDin", epcHDin, eEp);
    chk("badVaHWe", badVaHWe, eBvWe);
    if (eBvWe != 0) chk("badVaHDin", badVaHDin, eBv);
    chk("countHWe", countHWe, eCnWe);
    if (eCnWe != 0) chk("countHDin", countHDin, eCn);
    chk("redirect", {31'b0, redirect}, {31'b0, eRed});
    chk("redirectPc", redirectPc, eRpc);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    statusQ = '0; causeQ = '0; epcQ = '0; countQ = '0; compareQ = 32'd10;
    excValid = 0; excCode = '0; excPc = '0; excInDs = 0; excBadVa = '0; excBadVaValid = 0;
    eretValid = 0; instValid = 0; instPc = '0; instInDs = 0; hwIrq = '0; compareWrite = 0;
    pStWe = '0; pSt = '0; pCaWe = '0; pCa = '0; pEpWe = '0; pEp = '0; pCnWe = '0; pCn = '0;
    mCommit = 0; mTicks = 0; mLatch = 0;

    // Reset state
    step(); step();
    chk("reset_redirect", {31'b0, redirect}, 32'd0);
    chk("reset_causeHWe", causeHWe, 32'd0);
    rst = 1'b0;

    // Timer interrupt from Count reaching Compare
    statusQ = 32'h0000_8001; instValid = 1; instPc = 32'h100;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (redirect) begin got = 1; break; end
    end
    chk("timer_irq_seen", {31'b0, got}, 32'd1);
    chk("timer_irq_pc", redirectPc, VEC);
    chk("timer_irq_epc", epcHDin, 32'h100);
    chk("timer_irq_code", {27'b0, causeHDin[6:2]}, 32'd0);
    chk("timer_irq_ip7", {31'b0, causeHDin[15]}, 32'd1);
    chk("timer_irq_exl", statusHDin, 32'h2);
    instValid = 0;
    step(); step();
    chk("exl_blocks_irq", {31'b0, redirect}, 32'd0);

    // Exception in a delay slot with BadVAddr
    statusQ = 32'h0;
    excValid = 1; excCode = 5'd4; excPc = 32'h2004; excInDs = 1;
    excBadVa = 32'hDEAD_0001; excBadVaValid = 1;
    step();
    chk("exc_redirect", {31'b0, redirect}, 32'd1);
    chk("exc_epc", epcHDin, 32'h2000);
    chk("exc_bd", {31'b0, causeHDin[31]}, 32'd1);
    chk("exc_code", {27'b0, causeHDin[6:2]}, 32'd4);
    chk("exc_badva", badVaHDin, 32'hDEAD_0001);
    excValid = 0; excBadVaValid = 0;
    step(); step();

    // Nested exception with EXL already set
    excValid = 1; excCode = 5'd5; excInDs = 0;
    step();
    chk("nested_epcHWe", epcHWe, 32'd0);
    chk("nested_bdWe", {31'b0, causeHWe[31]}, 32'd0);
    chk("nested_code", {27'b0, causeHDin[6:2]}, 32'd5);
    chk("nested_pc", redirectPc, VEC);
    excValid = 0;
    step();

    // Exception and ERET together; ERET during COMMIT ignored; later ERET taken
    excValid = 1; eretValid = 1; excCode = 5'd8; epcQ = 32'h3000;
    step();
    chk("exc_eret_pc", redirectPc, VEC);
    excValid = 0;
    step();
    chk("eret_in_commit", {31'b0, redirect}, 32'd0);
    epcQ = 32'h3000;
    step();
    chk("eret_pc", redirectPc, 32'h3000);
    chk("eret_status", statusHDin, 32'h0);
    chk("eret_statusWe", statusHWe, 32'h2);
    eretValid = 0;
    step();

    // Count wrap at FFFF_FFFF
    got = 0;
    for (int i = 0; i < 4; i++) begin
      countQ = 32'hFFFF_FFFF;
      step();
      if (countHWe != 0) begin got = 1; chk("count_wrap", countHDin, 32'd0); break; end
    end
    chk("count_tick_seen", {31'b0, got}, 32'd1);

    // compareWrite beats a simultaneous Count==Compare
    compareQ = countQ; compareWrite = 1;
    step();
    chk("cmpwr_clear", {31'b0, causeHDin[15]}, 32'd0);
    compareWrite = 0; compareQ = countQ + 32'd100;
    step();
    chk("cmpwr_stay", {31'b0, causeHDin[30]}, 32'd0);

    // Pending interrupt but IE=0, then EXL=1
    statusQ = 32'h0000_0400; hwIrq = 5'b00001; instValid = 1; instPc = 32'h400;
    step(); step(); step();
    chk("ie0_no_irq", {31'b0, redirect}, 32'd0);
    statusQ = 32'h0000_0403;
    step(); step();
    chk("exl1_no_irq", {31'b0, redirect}, 32'd0);
    hwIrq = '0; instValid = 0; statusQ = 32'h0;
    step(); step();

    // Reset during COMMIT
    excValid = 1; excCode = 5'd10;
    step();
    chk("pre_rst_redirect", {31'b0, redirect}, 32'd1);
    excValid = 0; rst = 1;
    step();
    chk("rst_commit_redirect", {31'b0, redirect}, 32'd0);
    rst = 0;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 60) == 0);
      excValid      = ($urandom_range(0, 7) == 0);
      excCode       = 5'($urandom);
      excPc         = {$urandom} & 32'hFFFF_FFFC;
      excInDs       = 1'($urandom);
      excBadVa      = $urandom;
      excBadVaValid = 1'($urandom);
      eretValid     = ($urandom_range(0, 7) == 0);
      instValid     = 1'($urandom);
      instPc        = {$urandom} & 32'hFFFF_FFFC;
      instInDs      = 1'($urandom);
      hwIrq         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      compareWrite  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) compareQ = countQ;
      else if ($urandom_range(0, 5) == 0) compareQ = $urandom;
      if ($urandom_range(0, 9) == 0)
        statusQ = {16'b0, 8'($urandom), 5'b0, 3'($urandom)};
      if ($urandom_range(0, 9) == 0) epcQ = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
